flowreg_pack: RTL and testbench

FLOWREG_PACK -- requirements
Module: flowreg_pack

---
 rtl/flowreg_pack.sv | 131 +++++++++++++
 tb/tb_flowreg_pack.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/flowreg_pack.sv
`default_nettype none
// ===========================================================================
// Module   : flowreg_pack
// Purpose  : Width-up packer. Collects N consecutive upstream words of W bits
//            into one N*W-bit downstream word, with lane 0 in the LSBs.
//            Valid/ready handshakes on both sides. A new group may be
//            accepted on the same edge the previous packed word is consumed,
//            so a sustained stream gives one packed word every N cycles.
// Ports    : clk    - clock, rising edge
//            rst    - asynchronous reset, active low
//            d_u    - upstream word [W-1:0]
//            v_u    - upstream valid
//            r_u    - ready to upstream (= !v_d || r_d)
//            d_d    - packed word [N*W-1:0], lane i = d_d[i*W +: W]
//            v_d    - downstream valid
//            r_d    - downstream ready
//            flush  - (FLOWREG_PACK_FLUSH_EN only) present a partial group
//            n_d    - (FLOWREG_PACK_FLUSH_EN only) lanes holding data in d_d
// Macro    : FLOWREG_PACK_FLUSH_EN adds the flush input and n_d output.
// Revision : 1.0 - initial release
// ===========================================================================
module flowreg_pack #(
   parameter int W = 8,
   parameter int N = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     d_u,
   input  logic             v_u,
   output logic             r_u,
   output logic [N*W-1:0]   d_d,
   output logic             v_d,
   input  logic             r_d
`ifdef FLOWREG_PACK_FLUSH_EN
   ,
   input  logic             flush,
   output logic [$clog2(N+1)-1:0] n_d
`endif
);

   // Lane counter needs at least one bit even when N = 1.
   localparam int            c_cnt_w = (N > 1) ? $clog2(N) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N - 1);

   logic [c_cnt_w-1:0] r_cnt;
   logic               r_vd;

   logic w_accept;
   logic w_consume;
   logic w_last;
   logic w_flush_fire;

   assign r_u       = !r_vd || r_d;
   assign w_accept  = v_u && r_u;
   assign w_consume = r_vd && r_d;
   assign w_last    = (r_cnt == c_last);

`ifdef FLOWREG_PACK_FLUSH_EN
   // Flush only matters when there is something to present: a partial
   // group already held, or a word arriving on this very edge.
   assign w_flush_fire = flush && ((r_cnt != '0) || w_accept);
`else
   assign w_flush_fire = 1'b0;
`endif

   // Lane counter: advances per accepted word, restarts on group end/flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (w_flush_fire) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= w_last ? '0 : r_cnt + c_cnt_w'(1);
      end
   end

   // Downstream valid. A completing accept or a flush wins over a consume,
   // which is what makes consume+accept on one edge lossless.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vd <= 1'b0;
      end else if ((w_accept && w_last) || w_flush_fire) begin
         r_vd <= 1'b1;
      end else if (w_consume) begin
         r_vd <= 1'b0;
      end
   end

   assign v_d = r_vd;

   // Per-lane data registers. Lane i loads on an accept at cnt == i; an
   // accept into lane 0 zeroes every other lane so a short (flushed) group
   // never shows stale data from the previous group.
   for (genvar i = 0; i < N; i++) begin : g_lane
      localparam logic [c_cnt_w-1:0] c_idx = c_cnt_w'(i);
      logic [W-1:0] r_lane;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_lane <= '0;
         end else if (w_accept) begin
            if (r_cnt == c_idx) begin
               r_lane <= d_u;
            end else if (r_cnt == '0) begin
               r_lane <= '0;
            end
         end
      end

      assign d_d[i*W +: W] = r_lane;
   end

`ifdef FLOWREG_PACK_FLUSH_EN
   // n_d tracks how many lanes of d_d were written in the current group;
   // it therefore reads N for a full group and the partial count on flush.
   localparam int c_nd_w = $clog2(N + 1);
   logic [c_nd_w-1:0] r_nd;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_nd <= '0;
      end else if (w_accept) begin
         r_nd <= c_nd_w'(r_cnt) + c_nd_w'(1);
      end
   end

   assign n_d = r_nd;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flowreg_pack.sv
`default_nettype none
// ===========================================================================
// Module   : tb_flowreg_pack
// Purpose  : Self-checking bench for flowreg_pack (W=8, N=4). Packed words
//            are pushed to a scoreboard queue when the completing stimulus
//            is driven and popped/compared when the DUT presents and the
//            bench consumes them. Scenario tasks add inline checks.
// Revision : 1.0 - initial release
// ===========================================================================
module tb_flowreg_pack;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [W-1:0]   d_u;
   logic           v_u;
   logic           r_u;
   logic [N*W-1:0] d_d;
   logic           v_d;
   logic           r_d;
`ifdef FLOWREG_PACK_FLUSH_EN
   logic           flush;
   logic [2:0]     n_d;
`endif

   int             n_vec = 0;
   int             n_err = 0;
   logic [N*W-1:0] sb_q[$];

   flowreg_pack #(.W(W), .N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .d_u   (d_u),
      .v_u   (v_u),
      .r_u   (r_u),
      .d_d   (d_d),
      .v_d   (v_d),
      .r_d   (r_d)
`ifdef FLOWREG_PACK_FLUSH_EN
      ,
      .flush (flush),
      .n_d   (n_d)
`endif
   );

   always #5 clk = ~clk;

   // One cycle of stimulus: inputs change 2 time units after the rising
   // edge; at the following falling edge a pending consume is scored.
   task automatic drive(input logic vu, input logic [W-1:0] du, input logic rd);
      logic [N*W-1:0] exp;
      @(posedge clk);
      #2;
      v_u = vu;
      d_u = du;
      r_d = rd;
      @(negedge clk);
      if (rst && v_d && r_d) begin
         n_vec++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_pop: got d_d=%h, no packed word expected", d_d);
         end else begin
            exp = sb_q.pop_front();
            if (d_d !== exp) begin
               n_err++;
               $display("FAIL sb_data: got d_d=%h, expected %h", d_d, exp);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; v_u = 1'b0; d_u = '0; r_d = 1'b1;
`ifdef FLOWREG_PACK_FLUSH_EN
      flush = 1'b0;
`endif
      #1 rst = 1'b0;
      #2;
      n_vec++; if (v_d !== 1'b0) begin n_err++; $display("FAIL reset_v_d: got %b, expected 0", v_d); end
      n_vec++; if (d_d !== '0) begin n_err++; $display("FAIL reset_d_d: got %h, expected 0", d_d); end
      n_vec++; if (r_u !== 1'b1) begin n_err++; $display("FAIL reset_r_u: got %b, expected 1", r_u); end
`ifdef FLOWREG_PACK_FLUSH_EN
      n_vec++; if (n_d !== 3'd0) begin n_err++; $display("FAIL reset_n_d: got %0d, expected 0", n_d); end
`endif
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 8'((k + 1) * 8'h11), 1'b1);
         n_vec++; if (r_u !== 1'b1) begin n_err++; $display("FAIL basic_r_u[%0d]: got %b, expected 1", k, r_u); end
      end
      sb_q.push_back(32'h44332211);
      drive(1'b0, '0, 1'b1);
      n_vec++; if (v_d !== 1'b1) begin n_err++; $display("FAIL basic_v_d: got %b, expected 1", v_d); end
      n_vec++; if (d_d !== 32'h44332211) begin n_err++; $display("FAIL basic_d_d: got %h, expected 44332211", d_d); end
      drive(1'b0, '0, 1'b1);
      n_vec++; if (v_d !== 1'b0) begin n_err++; $display("FAIL basic_v_d_clr: got %b, expected 0", v_d); end
   endtask

   task automatic test_stall();
      for (int k = 0; k < 4; k++) drive(1'b1, 8'(8'h51 + k), 1'b0);
      sb_q.push_back(32'h54535251);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 8'hEE, 1'b0);
         n_vec++; if (v_d !== 1'b1) begin n_err++; $display("FAIL stall_v_d[%0d]: got %b, expected 1", k, v_d); end
         n_vec++; if (r_u !== 1'b0) begin n_err++; $display("FAIL stall_r_u[%0d]: got %b, expected 0", k, r_u); end
         n_vec++; if (d_d !== 32'h54535251) begin n_err++; $display("FAIL stall_d_d[%0d]: got %h, expected 54535251", k, d_d); end
      end
      drive(1'b0, '0, 1'b1);
      n_vec++; if (r_u !== 1'b1) begin n_err++; $display("FAIL stall_release_r_u: got %b, expected 1", r_u); end
      drive(1'b0, '0, 1'b1);
      n_vec++; if (v_d !== 1'b0) begin n_err++; $display("FAIL stall_v_d_clr: got %b, expected 0", v_d); end
   endtask

   task automatic test_back_to_back();
      logic [N*W-1:0] grp;
      grp = '0;
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 8'(i), 1'b1);
         n_vec++; if (r_u !== 1'b1) begin n_err++; $display("FAIL b2b_r_u[%0d]: got %b, expected 1", i, r_u); end
         grp[(i % 4)*W +: W] = 8'(i);
         if ((i % 4) == 3) sb_q.push_back(grp);
      end
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b1);
      n_vec++; if (sb_q.size() != 0) begin n_err++; $display("FAIL b2b_drain: got %0d words left, expected 0", sb_q.size()); end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 8'hAA, 1'b1);
      drive(1'b1, 8'hBB, 1'b1);
      // Previous group had non-zero upper lanes; lane-0 accept must clear them.
      n_vec++; if (d_d !== 32'h000000AA) begin n_err++; $display("FAIL arst_lane_clr: got %h, expected 000000AA", d_d); end
      drive(1'b0, '0, 1'b1);
      n_vec++; if (d_d !== 32'h0000BBAA) begin n_err++; $display("FAIL arst_partial: got %h, expected 0000BBAA", d_d); end
      #1 rst = 1'b0;
      #1;
      n_vec++; if (v_d !== 1'b0) begin n_err++; $display("FAIL arst_v_d: got %b, expected 0", v_d); end
      n_vec++; if (d_d !== '0) begin n_err++; $display("FAIL arst_d_d: got %h, expected 0", d_d); end
      n_vec++; if (r_u !== 1'b1) begin n_err++; $display("FAIL arst_r_u: got %b, expected 1", r_u); end
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) drive(1'b1, 8'(8'h61 + k), 1'b1);
      sb_q.push_back(32'h64636261);
      drive(1'b0, '0, 1'b1);
      n_vec++; if (d_d !== 32'h64636261) begin n_err++; $display("FAIL arst_repack: got %h, expected 64636261", d_d); end
      drive(1'b0, '0, 1'b1);
   endtask

`ifdef FLOWREG_PACK_FLUSH_EN
   task automatic test_flush();
      drive(1'b1, 8'h01, 1'b1);
      drive(1'b1, 8'h02, 1'b1);
      drive(1'b0, '0, 1'b0);
      flush = 1'b1;
      sb_q.push_back(32'h00000201);
      drive(1'b0, '0, 1'b0);
      flush = 1'b0;
      n_vec++; if (v_d !== 1'b1) begin n_err++; $display("FAIL flush_v_d: got %b, expected 1", v_d); end
      n_vec++; if (d_d !== 32'h00000201) begin n_err++; $display("FAIL flush_d_d: got %h, expected 00000201", d_d); end
      n_vec++; if (n_d !== 3'd2) begin n_err++; $display("FAIL flush_n_d: got %0d, expected 2", n_d); end
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b1);
      flush = 1'b1;
      drive(1'b0, '0, 1'b1);
      flush = 1'b0;
      n_vec++; if (v_d !== 1'b0) begin n_err++; $display("FAIL flush_idle_v_d: got %b, expected 0", v_d); end
      // Flush on the edge that accepts the third word.
      drive(1'b1, 8'h01, 1'b1);
      drive(1'b1, 8'h02, 1'b1);
      drive(1'b1, 8'h03, 1'b1);
      flush = 1'b1;
      sb_q.push_back(32'h00030201);
      drive(1'b0, '0, 1'b0);
      flush = 1'b0;
      n_vec++; if (d_d !== 32'h00030201) begin n_err++; $display("FAIL flush3_d_d: got %h, expected 00030201", d_d); end
      n_vec++; if (n_d !== 3'd3) begin n_err++; $display("FAIL flush3_n_d: got %0d, expected 3", n_d); end
      drive(1'b0, '0, 1'b1);
      for (int k = 0; k < 4; k++) drive(1'b1, 8'(8'hC1 + k), 1'b1);
      sb_q.push_back(32'hC4C3C2C1);
      drive(1'b0, '0, 1'b1);
      n_vec++; if (n_d !== 3'd4) begin n_err++; $display("FAIL full_n_d: got %0d, expected 4", n_d); end
      drive(1'b0, '0, 1'b1);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_async_reset();
`ifdef FLOWREG_PACK_FLUSH_EN
      test_flush();
`endif
      n_vec++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_leftover: got %0d words pending, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
